// File: rtl/instr_encode_loader.sv
// Symbolic-instruction encoder that streams packed 9-bit words into
// instruction memory for program loading ahead of core release.
module instr_encode_loader #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cls,
    input  logic [3:0]    in_a,
    input  logic [2:0]    in_b,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [8:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   ww_q;
    logic          err_q;
    logic          we_q;
    logic          wlast_q;
    logic [AW-1:0] addr_q;
    logic [8:0]    wdata_q;

    logic [5:0]    op;
    logic          legal;
    logic          accept;
    logic          wr_acc;
    logic          bad_last;
    logic          enter_load;
    logic          full_done;
    logic          last_done;
    logic [AW+1:0] occ;

    always_comb begin
        op    = 6'b000000;
        legal = 1'b1;
        unique case (in_cls)
            4'd0: op = {3'b000, in_a[2:0]};
            4'd1: op = 6'b001000;
            4'd2: op = 6'b001001;
            4'd3: op = 6'b001010;
            4'd4: begin
                op    = {2'b01, in_a};
                legal = (in_a[2:0] != 3'b101);
            end
            4'd5: op = {2'b01, in_a[3], 3'b101};
            4'd6: op = {3'b100, in_a[2:0]};
            4'd7: op = {3'b101, in_a[2:0]};
            4'd8: op = {3'b110, in_a[2:0]};
            4'd9: op = {3'b111, in_a[2:0]};
            default: legal = 1'b0;
        endcase
    end

    // Occupancy counts the word still in flight on the write port.
    assign occ        = {1'b0, ww_q} + {{(AW+1){1'b0}}, we_q};
    assign accept     = in_valid & in_ready;
    assign wr_acc     = accept & legal;
    assign bad_last   = accept & ~legal & in_last;
    assign enter_load = start & (state_q != S_LOAD);
    assign full_done  = we_q & (occ == DEPTH_C);
    assign last_done  = we_q & wlast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bad_last || last_done || full_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == S_LOAD);
        done     = (state_q == S_DONE);
        in_ready = (state_q == S_LOAD) && (occ < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wlast_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= wr_acc;
            wlast_q <= wr_acc & in_last;
            if (wr_acc) begin
                addr_q  <= ptr_q;
                wdata_q <= {op, in_b};
            end
            if (enter_load) begin
                ptr_q <= '0;
                ww_q  <= '0;
                err_q <= 1'b0;
            end else begin
                if (wr_acc) ptr_q <= ptr_q + AW'(1);
                if (we_q) ww_q <= ww_q + (AW+1)'(1);
                if (accept && !legal) err_q <= 1'b1;
            end
        end
    end

    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign err           = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: encoding table, load sequences,
// full-memory stop, reset abort and randomized loads vs a model.
module tb_instr_encode_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start4;
    logic       in_valid;
    logic [3:0] in_cls;
    logic [3:0] in_a;
    logic [2:0] in_b;
    logic       in_last;

    logic       in_ready, mem_we, busy, done, err;
    logic [7:0] mem_addr;
    logic [8:0] mem_wdata;
    logic [8:0] ww;

    logic       in_ready4, mem_we4, busy4, done4, err4;
    logic [7:0] mem_addr4;
    logic [8:0] mem_wdata4;
    logic [8:0] ww4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cls;
        int a;
        int b;
        bit last;
    } beat_t;

    typedef struct {
        int cls;
        int a;
        int b;
        bit legal;
        int word;
    } vec_t;

    beat_t       bq[$];
    logic [16:0] obs[$];
    logic [16:0] obs4[$];
    vec_t        vt[15];

    always #5 clk = ~clk;

    instr_encode_loader #(.AW(8), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cls(in_cls), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .words_written(ww)
    );

    instr_encode_loader #(.AW(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_cls(in_cls), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .busy(busy4), .done(done4), .err(err4), .words_written(ww4)
    );

    always @(negedge clk) begin
        if (mem_we) obs.push_back({mem_addr, mem_wdata});
        if (mem_we4) obs4.push_back({mem_addr4, mem_wdata4});
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Opcode map written as arithmetic on the class table.
    function automatic bit ref_enc(input int cls, input int a, input int b,
                                   output int w);
        int op;
        op = 0;
        w  = 0;
        case (cls)
            0: op = a % 8;
            1: op = 8;
            2: op = 9;
            3: op = 10;
            4: begin
                if (a % 8 == 5) return 1'b0;
                op = 16 + a;
            end
            5: op = 16 + (a / 8) * 8 + 5;
            6, 7, 8, 9: op = (cls - 2) * 8 + a % 8;
            default: return 1'b0;
        endcase
        w = op * 8 + b;
        return 1'b1;
    endfunction

    function automatic int obs_at(input bit u4, input int i);
        if (u4) return (i < obs4.size()) ? int'(obs4[i]) : -1;
        return (i < obs.size()) ? int'(obs[i]) : -1;
    endfunction

    task automatic pulse_start(input bit u4);
        @(negedge clk);
        if (u4) start4 = 1'b1;
        else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic send_beat(input bit u4, input beat_t bt);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_cls   = 4'(bt.cls);
        in_a     = 4'(bt.a);
        in_b     = 3'(bt.b);
        in_last  = bt.last;
        while (n < 50) begin
            if (u4 ? in_ready4 : in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input bit u4);
        int n;
        n = 0;
        while (!(u4 ? done4 : done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("done", int'(u4 ? done4 : done), 1);
    endtask

    // Sends bq as one program and compares against the model.
    task automatic do_load(input bit rnd_gap);
        int exw[$];
        int ptr, w;
        bit exerr;
        ptr   = 0;
        exerr = 1'b0;
        foreach (bq[i]) begin
            if (ref_enc(bq[i].cls, bq[i].a, bq[i].b, w)) begin
                exw.push_back(ptr * 512 + w);
                ptr++;
            end else begin
                exerr = 1'b1;
            end
            if (bq[i].last) break;
        end
        obs.delete();
        pulse_start(1'b0);
        foreach (bq[i]) begin
            if (rnd_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(1'b0, bq[i]);
        end
        wait_done(1'b0);
        chk("nwrites", obs.size(), exw.size());
        foreach (exw[i]) chk("write", obs_at(1'b0, i), exw[i]);
        chk("err", int'(err), int'(exerr));
        chk("words_written", int'(ww), exw.size());
    endtask

    initial begin
        int  acc;
        bit  seen;
        int  w;
        vt[0]  = '{1, 0, 0, 1'b1, 'h040};
        vt[1]  = '{6, 3, 5, 1'b1, 'h11D};
        vt[2]  = '{9, 2, 7, 1'b1, 'h1D7};
        vt[3]  = '{0, 1, 0, 1'b1, 'h008};
        vt[4]  = '{0, 2, 1, 1'b1, 'h011};
        vt[5]  = '{4, 5, 3, 1'b0, 0};
        vt[6]  = '{4, 13, 3, 1'b0, 0};
        vt[7]  = '{4, 12, 3, 1'b1, 'h0E3};
        vt[8]  = '{5, 8, 2, 1'b1, 'h0EA};
        vt[9]  = '{12, 0, 0, 1'b0, 0};
        vt[10] = '{15, 7, 7, 1'b0, 0};
        vt[11] = '{2, 0, 6, 1'b1, 'h04E};
        vt[12] = '{3, 0, 1, 1'b1, 'h051};
        vt[13] = '{7, 5, 4, 1'b1, 'h16C};
        vt[14] = '{8, 7, 0, 1'b1, 'h1B8};

        rst_n    = 1'b0;
        start    = 1'b0;
        start4   = 1'b0;
        in_valid = 1'b0;
        in_cls   = '0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
        #13;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ww", int'(ww), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        foreach (vt[i]) begin
            bq.delete();
            bq.push_back('{vt[i].cls, vt[i].a, vt[i].b, 1'b1});
            do_load(1'b0);
            chk("tbl_nw", obs.size(), vt[i].legal ? 1 : 0);
            if (vt[i].legal) chk("tbl_word", obs_at(1'b0, 0), vt[i].word);
            chk("tbl_err", int'(err), vt[i].legal ? 0 : 1);
        end

        bq.delete();
        bq.push_back('{1, 0, 0, 1'b0});
        bq.push_back('{6, 3, 5, 1'b0});
        bq.push_back('{9, 2, 7, 1'b1});
        do_load(1'b0);
        chk("tp1_w0", obs_at(1'b0, 0), 'h00040);
        chk("tp1_w1", obs_at(1'b0, 1), 'h0031D);
        chk("tp1_w2", obs_at(1'b0, 2), 'h005D7);

        bq.delete();
        bq.push_back('{0, 1, 0, 1'b0});
        bq.push_back('{4, 5, 0, 1'b0});
        bq.push_back('{0, 2, 1, 1'b1});
        do_load(1'b0);
        chk("tp2_w0", obs_at(1'b0, 0), 'h00008);
        chk("tp2_w1", obs_at(1'b0, 1), 'h00211);

        bq.delete();
        bq.push_back('{0, 3, 3, 1'b0});
        bq.push_back('{12, 0, 0, 1'b1});
        do_load(1'b0);
        chk("ill_last_err", int'(err), 1);

        // start in DONE clears the load bookkeeping
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_ww", int'(ww), 0);
        chk("restart_err", int'(err), 0);
        chk("restart_busy", int'(busy), 1);
        obs.delete();
        send_beat(1'b0, '{1, 0, 0, 1'b1});
        wait_done(1'b0);
        chk("restart_w0", obs_at(1'b0, 0), 'h00040);

        // start during LOAD is ignored
        obs.delete();
        pulse_start(1'b0);
        send_beat(1'b0, '{0, 4, 4, 1'b0});
        pulse_start(1'b0);
        send_beat(1'b0, '{0, 5, 5, 1'b1});
        wait_done(1'b0);
        chk("ign_w0", obs_at(1'b0, 0), 'h00024);
        chk("ign_w1", obs_at(1'b0, 1), 'h0022D);
        chk("ign_ww", int'(ww), 2);

        // DEPTH=4 instance fills up with in_valid held high
        obs4.delete();
        pulse_start(1'b1);
        acc  = 0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (acc < 6);
            in_cls   = 4'd0;
            in_a     = 4'(acc);
            in_b     = 3'(acc);
            in_last  = 1'b0;
            if (in_ready4) acc++;
            @(negedge clk);
            if (acc == 4 && !seen) begin
                chk("full_ready_low", int'(in_ready4), 0);
                seen = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("full_accepts", acc, 4);
        chk("full_done", int'(done4), 1);
        chk("full_ww", int'(ww4), 4);
        chk("full_nw", obs4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            void'(ref_enc(0, i, i, w));
            chk("full_write", obs_at(1'b1, i), i * 512 + w);
        end

        // reset between accept and write drops the pending word
        obs.delete();
        pulse_start(1'b0);
        in_valid = 1'b1;
        in_cls   = 4'd1;
        in_a     = 4'd0;
        in_b     = 3'd0;
        in_last  = 1'b1;
        chk("abort_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we", int'(mem_we), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ww", int'(ww), 0);
        chk("abort_addr", int'(mem_addr), 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("abort_nw", obs.size(), 0);
        chk("abort_idle_ready", int'(in_ready), 0);
        bq.delete();
        bq.push_back('{7, 1, 2, 1'b1});
        do_load(1'b0);
        chk("abort_reload", obs_at(1'b0, 0), 'h0014A);

        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(1, 12);
            bq.delete();
            for (int k = 0; k < n; k++) begin
                bq.push_back('{int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 7)),
                               (k == n - 1)});
            end
            do_load(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
